// File: rtl/lsu_mem_stage_if.sv
// Data-bus bundle between the load/store unit and memory.
// One outstanding request at a time. busAck completes it, and busRdata is valid in the same cycle.
interface lsu_mem_stage_if #(
  parameter int WORDSIZE = 32
);
  logic                busReq;
  logic                busWe;
  logic [WORDSIZE-1:0] busAddr;
  logic [WORDSIZE-1:0] busWdata;
  logic [3:0]          busStrb;
  logic                busAck;
  logic [WORDSIZE-1:0] busRdata;

  modport master (
    output busReq, busWe, busAddr, busWdata, busStrb,
    input  busAck, busRdata
  );

  modport slave (
    input  busReq, busWe, busAddr, busWdata, busStrb,
    output busAck, busRdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit memory stage.
// It issues one bus access per memory instruction and stalls the core until the access finishes.
// It builds store strobes and replicated store data, and formats load results for write-back.
// It flags misaligned accesses, illegal encodings and bus timeouts with a one-cycle fault pulse.
module lsu_mem_stage #(
  parameter int WORDSIZE = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                memRead,
  input  logic                memWrite,
  input  logic [2:0]          funct3,
  input  logic [WORDSIZE-1:0] aluResult,
  input  logic [WORDSIZE-1:0] storeData,
  output logic [WORDSIZE-1:0] readData,
  output logic                stall,
  output logic                fault,
  output logic [1:0]          faultCause,
  lsu_mem_stage_if.master     bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [CW-1:0]       count;
  logic                timed_out;
  logic                load_q;
  logic [2:0]          size_q;
  logic [1:0]          lane_q;

  logic                access;
  logic                illegal;
  logic                misaligned;
  logic                start;
  logic                ack_now;
  logic                timeout_now;
  logic                misalign_now;
  logic [3:0]          store_strb;
  logic [WORDSIZE-1:0] store_wdata;
  logic [7:0]          load_byte;
  logic [15:0]         load_half;
  logic [WORDSIZE-1:0] load_value;

  // Classify the instruction currently presented: is it an access, is it encodable, is it aligned
  always_comb begin
    access     = memRead | memWrite;
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (memRead & memWrite)
      illegal = 1'b1;
    else if (memRead)
      illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    else if (memWrite)
      illegal = funct3[2] || (funct3[1:0] == 2'b11);
    if ((funct3[1:0] == 2'b01) && aluResult[0])
      misaligned = 1'b1;
    if ((funct3[1:0] == 2'b10) && (aluResult[1:0] != 2'b00))
      misaligned = 1'b1;
  end

  // Store lane strobes and lane-replicated write data for the presented store
  always_comb begin
    store_strb  = 4'b0000;
    store_wdata = '0;
    case (funct3[1:0])
      2'b00: begin
        store_strb  = 4'b0001 << aluResult[1:0];
        store_wdata = {4{storeData[7:0]}};
      end
      2'b01: begin
        store_strb  = 4'b0011 << aluResult[1:0];
        store_wdata = {2{storeData[15:0]}};
      end
      default: begin
        store_strb  = 4'b1111;
        store_wdata = storeData;
      end
    endcase
  end

  // Pick the addressed byte/halfword out of the returned word and extend it to full width
  always_comb begin
    load_value = bus.busRdata;
    case (lane_q)
      2'b00:   load_byte = bus.busRdata[7:0];
      2'b01:   load_byte = bus.busRdata[15:8];
      2'b10:   load_byte = bus.busRdata[23:16];
      default: load_byte = bus.busRdata[31:24];
    endcase
    load_half = lane_q[1] ? bus.busRdata[31:16] : bus.busRdata[15:0];
    case (size_q)
      3'b000:  load_value = {{(WORDSIZE-8){load_byte[7]}}, load_byte};
      3'b001:  load_value = {{(WORDSIZE-16){load_half[15]}}, load_half};
      3'b100:  load_value = {{(WORDSIZE-8){1'b0}}, load_byte};
      3'b101:  load_value = {{(WORDSIZE-16){1'b0}}, load_half};
      default: load_value = bus.busRdata;
    endcase
  end

  // Next state, stall and fault decode; reset masks the combinational outputs
  always_comb begin
    next_state   = state;
    stall        = 1'b0;
    fault        = 1'b0;
    faultCause   = 2'b00;
    start        = 1'b0;
    ack_now      = 1'b0;
    timeout_now  = 1'b0;
    misalign_now = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (illegal) begin
            fault      = 1'b1;
            faultCause = 2'b10;
          end else if (misaligned) begin
            fault        = 1'b1;
            faultCause   = 2'b01;
            misalign_now = 1'b1;
          end else begin
            stall      = 1'b1;
            start      = 1'b1;
            next_state = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.busAck) begin
          ack_now    = 1'b1;
          next_state = DONE;
        end else if (count == CW'(TIMEOUT - 1)) begin
          timeout_now = 1'b1;
          next_state  = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
        if (timed_out) begin
          fault      = 1'b1;
          faultCause = 2'b11;
        end
      end
      default: next_state = IDLE;
    endcase
    if (rst) begin
      stall      = 1'b0;
      fault      = 1'b0;
      faultCause = 2'b00;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Count cycles spent waiting in REQ; a timeout is remembered so DONE can report it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      timed_out <= 1'b0;
    end else begin
      timed_out <= timeout_now;
      if (start)
        count <= '0;
      else if (state == REQ)
        count <= count + CW'(1);
    end
  end

  // Bus outputs are captured at the start of an access and held until the access completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busReq   <= 1'b0;
      bus.busWe    <= 1'b0;
      bus.busAddr  <= '0;
      bus.busWdata <= '0;
      bus.busStrb  <= 4'b0000;
      load_q       <= 1'b0;
      size_q       <= 3'b000;
      lane_q       <= 2'b00;
    end else if (start) begin
      bus.busReq   <= 1'b1;
      bus.busWe    <= memWrite;
      bus.busAddr  <= {aluResult[WORDSIZE-1:2], 2'b00};
      bus.busWdata <= memWrite ? store_wdata : '0;
      bus.busStrb  <= memWrite ? store_strb : 4'b0000;
      load_q       <= memRead;
      size_q       <= funct3;
      lane_q       <= aluResult[1:0];
    end else if (ack_now || timeout_now) begin
      bus.busReq <= 1'b0;
    end
  end

  // Load result register: set on a completed load, cleared by misalignment or timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      readData <= '0;
    else if (ack_now && load_q)
      readData <= load_value;
    else if (timeout_now || misalign_now)
      readData <= '0;
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Testbench for lsu_mem_stage.
// Directed accesses come first, followed by randomized ones.
// Each access is compared against a byte-level reference model.
module tb_lsu_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] aluResult;
  logic [31:0] storeData;
  logic [31:0] readData;
  logic        stall;
  logic        fault;
  logic [1:0]  faultCause;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_read;

  lsu_mem_stage_if #(.WORDSIZE(32)) bus ();

  lsu_mem_stage #(.WORDSIZE(32), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .memRead(memRead),
    .memWrite(memWrite),
    .funct3(funct3),
    .aluResult(aluResult),
    .storeData(storeData),
    .readData(readData),
    .stall(stall),
    .fault(fault),
    .faultCause(faultCause),
    .bus(bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case a step never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Bytes touched by an access of this funct3
  function automatic int access_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // 0 = ok, 1 = misaligned, 2 = illegal
  function automatic int classify(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr);
    if (rd && wr) return 2;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 2;
    if ((addr % access_size(f3)) != 0) return 1;
    return 0;
  endfunction

  // Load result from the byte-addressed view of the word
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    longint unsigned size, offset, raw, val;
    size   = longint'(access_size(f3));
    offset = ((addr % 4) / size) * size;
    raw    = ({32'd0, word} >> (8 * offset)) % (64'd1 << (8 * size));
    val    = raw;
    if (!f3[2] && size < 4 && raw >= (64'd1 << (8 * size - 1)))
      val = raw - (64'd1 << (8 * size));
    return val[31:0];
  endfunction

  // One strobe bit per byte written
  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] s;
    int first, size;
    s = 4'b0000;
    size = access_size(f3);
    first = int'(addr % 4);
    for (int i = 0; i < 4; i++)
      if (i >= first && i < first + size) s[i] = 1'b1;
    return s;
  endfunction

  // Store value copied into every lane-sized slot of the word
  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] data);
    longint unsigned piece, w;
    int size;
    size  = access_size(f3);
    piece = {32'd0, data} % (64'd1 << (8 * size));
    w     = 0;
    for (int i = 0; i < 4 / size; i++)
      w = w + (piece << (8 * size * i));
    return w[31:0];
  endfunction

  // One counted comparison
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  // One complete instruction; the bench answers busAck on REQ cycle ack_cycle (> TO means never)
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] rdata, input int ack_cycle);
    int  kind;
    bit  acked;
    logic [31:0] noise;
    kind = classify(rd, wr, f3, addr);
    memRead = rd; memWrite = wr; funct3 = f3; aluResult = addr; storeData = sdata;
    #1;
    if (!(rd || wr)) begin
      checkOutput("idle_stall", 32'(stall), 32'd0);
      checkOutput("idle_fault", 32'(fault), 32'd0);
      @(posedge clk); #1;
      checkOutput("idle_busreq", 32'(bus.busReq), 32'd0);
      return;
    end
    if (kind != 0) begin
      checkOutput("bad_fault", 32'(fault), 32'd1);
      checkOutput("bad_cause", 32'(faultCause), (kind == 2) ? 32'd2 : 32'd1);
      checkOutput("bad_stall", 32'(stall), 32'd0);
      checkOutput("bad_busreq", 32'(bus.busReq), 32'd0);
      @(posedge clk); #1;
      memRead = 1'b0; memWrite = 1'b0; #1;
      if (kind == 1) exp_read = 32'd0;
      checkOutput("bad_busreq_after", 32'(bus.busReq), 32'd0);
      checkOutput("bad_readdata", readData, exp_read);
      return;
    end
    checkOutput("idle_start_stall", 32'(stall), 32'd1);
    checkOutput("idle_start_fault", 32'(fault), 32'd0);
    @(posedge clk); #1;
    acked = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      checkOutput("req_busreq", 32'(bus.busReq), 32'd1);
      checkOutput("req_stall", 32'(stall), 32'd1);
      checkOutput("req_addr", bus.busAddr, addr - (addr % 4));
      checkOutput("req_we", 32'(bus.busWe), 32'(wr));
      checkOutput("req_strb", 32'(bus.busStrb), wr ? 32'(model_strb(f3, addr)) : 32'd0);
      if (wr) checkOutput("req_wdata", bus.busWdata, model_wdata(f3, sdata));
      noise = $urandom;
      bus.busAck   = (k == ack_cycle);
      bus.busRdata = (k == ack_cycle) ? rdata : noise;
      @(posedge clk); #1;
      bus.busAck = 1'b0;
      if (k == ack_cycle) begin
        acked = 1'b1;
        break;
      end
    end
    if (!acked) exp_read = 32'd0;
    else if (rd) exp_read = model_load(f3, addr, rdata);
    checkOutput("done_busreq", 32'(bus.busReq), 32'd0);
    checkOutput("done_stall", 32'(stall), 32'd0);
    checkOutput("done_fault", 32'(fault), acked ? 32'd0 : 32'd1);
    checkOutput("done_cause", 32'(faultCause), acked ? 32'd0 : 32'd3);
    checkOutput("done_readdata", readData, exp_read);
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0; #1;
    checkOutput("after_busreq", 32'(bus.busReq), 32'd0);
    checkOutput("after_fault", 32'(fault), 32'd0);
    checkOutput("after_readdata", readData, exp_read);
  endtask

  initial begin
    int sel, low, ack_cycle;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] rnd, addr, sdata, rdata;

    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'b000;
    aluResult = '0; storeData = '0; bus.busAck = 1'b0; bus.busRdata = '0;
    exp_read = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_readdata", readData, 32'd0);
    checkOutput("rst_busreq", 32'(bus.busReq), 32'd0);
    checkOutput("rst_busaddr", bus.busAddr, 32'd0);
    checkOutput("rst_busstrb", 32'(bus.busStrb), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed loads");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 2);
    checkOutput("plan_lw", readData, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF0000, 1);
    checkOutput("plan_lb", readData, 32'hFFFFFF80);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF0000, 1);
    checkOutput("plan_lbu", readData, 32'h00000080);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 32'h80FF0000, 3);
    checkOutput("plan_lhu", readData, 32'h000080FF);

    $display("[TB] directed stores");
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 32'd0, 1);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h202, 32'h12345678, 32'd0, 2);
    checkOutput("plan_store_keeps_readdata", readData, 32'h000080FF);

    $display("[TB] directed faults");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 1);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h100, 32'd0, 32'd0, 1);
    applyStimulus(1'b0, 1'b1, 3'b100, 32'h100, 32'd0, 32'd0, 1);

    $display("[TB] timeout boundary");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'h11111111, TO + 1);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h108, 32'd0, 32'hCAFEF00D, TO);
    checkOutput("plan_ack_at_limit", readData, 32'hCAFEF00D);

    $display("[TB] reset during REQ");
    memRead = 1'b1; memWrite = 1'b0; funct3 = 3'b010; aluResult = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    exp_read = 32'd0;
    checkOutput("midrst_busreq", 32'(bus.busReq), 32'd0);
    checkOutput("midrst_stall", 32'(stall), 32'd0);
    checkOutput("midrst_readdata", readData, 32'd0);
    @(posedge clk); #1;
    memRead = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("postrst_busreq", 32'(bus.busReq), 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'h0BADC0DE, 1);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      rd  = (sel == 1) || (sel >= 2 && sel <= 5);
      wr  = (sel == 1) || (sel >= 6);
      if ($urandom_range(0, 3) == 0)
        f3 = 3'($urandom_range(0, 7));
      else if (wr)
        f3 = 3'($urandom_range(0, 2));
      else begin
        low = $urandom_range(0, 4);
        f3 = (low < 3) ? 3'(low) : 3'(low + 1);
      end
      rnd   = $urandom;
      low   = $urandom_range(0, 3);
      addr  = {rnd[31:2], 2'(low)};
      sdata = $urandom;
      rdata = $urandom;
      ack_cycle = $urandom_range(1, TO + 1);
      applyStimulus(rd, wr, f3, addr, sdata, rdata, ack_cycle);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit between the ALU result and the write-back select. It sits directly upstream of the write-back mux and supplies its `readData` operand.
- Drives a single-outstanding request/acknowledge data bus and stalls the core until the access completes.
- Builds byte-lane strobes and replicated store data for stores. For loads it extracts and sign- or zero-extends the returned data.
- Detects misaligned accesses, illegal encodings and bus timeouts.

Parameters:
- WORDSIZE, 32, data and address width. Only 32 is supported (4 byte lanes).
- TIMEOUT, 255, maximum number of cycles in REQ without `busAck` before a fault is raised.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- memRead  input  1  current instruction is a load
- memWrite  input  1  current instruction is a store
- funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- aluResult  input  WORDSIZE  effective byte address
- storeData  input  WORDSIZE  rs2 value
- readData  output  WORDSIZE  formatted load result, routed to the write-back mux
- stall  output  1  holds PC and register write enable while high
- fault  output  1  one-cycle fault pulse
- faultCause  output  2  01 misaligned, 10 illegal, 11 timeout, 00 none
- busReq  output  1  request valid
- busWe  output  1  1 = write
- busAddr  output  WORDSIZE  word-aligned address (low two bits forced to 0)
- busWdata  output  WORDSIZE  lane-replicated store data
- busStrb  output  4  byte-lane write strobes
- busAck  input  1  request complete; `busRdata` is valid in the same cycle
- busRdata  input  WORDSIZE  read word

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-high.
  - Asserting `rst` forces the FSM to IDLE and clears the timeout counter.
  - `readData`, `busReq`, `busWe`, `busAddr`, `busWdata`, `busStrb`, `fault` and `faultCause` all go to 0.
  - An in-flight request is abandoned; `busReq` drops asynchronously.
- FSM states are IDLE, REQ and DONE.
- IDLE:
  - An access is `memRead | memWrite`.
  - Legal, aligned access: register the bus outputs, go to REQ. `stall` is 1 combinationally in this cycle.
  - Illegal access: `memRead & memWrite`, or a load `funct3` outside {000,001,010,100,101}, or a store `funct3` outside {000,001,010}.
    - `fault`=1 with cause 10 for one cycle, `stall`=0, no bus activity.
  - Misaligned access: H with `aluResult[0]`=1, or W with `aluResult[1:0]`≠0.
    - `fault`=1 with cause 01, `stall`=0, `readData`=0, no bus activity.
  - Illegal takes priority over misaligned.
- REQ:
  - `busReq`=1 and `stall`=1. All `bus*` outputs are held stable until `busAck`.
  - On `busAck`: register the formatted `readData` (loads only; stores leave it unchanged), drop `busReq` on the next edge, go to DONE.
  - The counter increments each REQ cycle. If it reaches TIMEOUT with no `busAck`, go to DONE with `fault`=1, cause 11, `readData`=0.
  - `busAck` in the same cycle the counter hits TIMEOUT counts as success.
- DONE:
  - `stall`=0 for exactly one cycle, so the core retires the instruction and write-back sees `readData`.
  - Always return to IDLE. The access inputs are ignored in DONE, which prevents a restart of the same instruction.
  - Back-to-back memory instructions therefore cost at least 3 cycles each (IDLE, REQ, DONE).
- Store formatting, where `a = aluResult[1:0]`:
  - SB: `busWdata` = `{4{storeData[7:0]}}`, `busStrb` = 0001 << a.
  - SH: `busWdata` = `{2{storeData[15:0]}}`, `busStrb` = 0011 << a.
  - SW: `busWdata` = `storeData`, `busStrb` = 1111.
  - Loads drive `busStrb` = 0000 and `busWe` = 0.
- Load formatting:
  - Select the byte at lane a, or the halfword at lane a[1].
  - B and H are sign-extended to 32 bits; BU and HU are zero-extended; W passes through.
- Without a new load, `readData` holds its last value.
- `fault` is a single-cycle pulse and is 0 at all other times.

Test Plan:
- LW at 0x100, `busAck` on the 2nd REQ cycle with `busRdata`=0xDEADBEEF:
  - `busAddr`=0x100, `stall` high for 3 cycles, DONE `readData`=0xDEADBEEF.
- LB at 0x103 with `busRdata`=0x80FF_0000 → `readData`=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080FF.
- SB at 0x201, `storeData`=0x12345678:
  - `busWe`=1, `busAddr`=0x200, `busStrb`=0010, `busWdata`=0x78787878.
  - SH at 0x202 → `busStrb`=1100, `busWdata`=0x56785678.
- LW at 0x102:
  - `fault`=1, `faultCause`=01, `stall` never asserts, `busReq` stays 0.
  - `memRead`=`memWrite`=1 → `faultCause`=10.
- TIMEOUT=4 with `busAck` held 0:
  - `busReq` high for 4 cycles, then DONE with `faultCause`=11, `readData`=0, `stall` released.
  - Ack on the 4th cycle → no fault.
- Assert `rst` in the 2nd REQ cycle:
  - `busReq`=0 immediately, state IDLE, `stall`=0.
  - A new LW after `rst` deasserts completes normally.
